imem_loader: RTL and testbench

Hardware boot loader that fills the instruction memory from a byte stream and holds the core until the image is complete. Sits between an external byte source (UART receiver or test harness) and the write port of the instruction memory, and drives the core hold line. It is the write-side counterpart of the core's instruction fetch: it is the only agent that writes instruction memory at boot, replacing backdoor loading.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams a framed byte image into instruction
// memory and holds the core until the image is loaded and its checksum matches.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t             r_state, w_state_nx;
  logic [15:0]        r_len, w_len_nx;
  logic [IDX_W-1:0]   r_idx, w_idx_nx;
  logic [1:0]         r_bcnt, w_bcnt_nx;
  logic [7:0]         r_sum, w_sum_nx;
  logic [23:0]        r_word, w_word_nx;
  logic               r_we, w_we_nx;
  logic [ADDR_W-1:0]  r_addr, w_addr_nx;
  logic [31:0]        r_wdata, w_wdata_nx;
  logic               r_hold, w_hold_nx;
  logic               r_done, w_done_nx;
  logic               r_error, w_error_nx;
  logic [1:0]         r_err_code, w_err_code_nx;
  logic               r_in_ready, w_in_ready_nx;

  logic               w_acc;
  logic [15:0]        w_n;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [31:0]        w_word_sh;

  // State and output registers; reset returns to IDLE with the core held.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_bcnt     <= '0;
      r_sum      <= '0;
      r_word     <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_len      <= w_len_nx;
      r_idx      <= w_idx_nx;
      r_bcnt     <= w_bcnt_nx;
      r_sum      <= w_sum_nx;
      r_word     <= w_word_nx;
      r_we       <= w_we_nx;
      r_addr     <= w_addr_nx;
      r_wdata    <= w_wdata_nx;
      r_hold     <= w_hold_nx;
      r_done     <= w_done_nx;
      r_error    <= w_error_nx;
      r_err_code <= w_err_code_nx;
      r_in_ready <= w_in_ready_nx;
    end
  end

  // Frame parser: next state, counters and registered output values.
  always_comb begin
    w_state_nx    = r_state;
    w_len_nx      = r_len;
    w_idx_nx      = r_idx;
    w_bcnt_nx     = r_bcnt;
    w_sum_nx      = r_sum;
    w_word_nx     = r_word;
    w_we_nx       = 1'b0;
    w_addr_nx     = r_addr;
    w_wdata_nx    = r_wdata;
    w_hold_nx     = r_hold;
    w_done_nx     = r_done;
    w_error_nx    = r_error;
    w_err_code_nx = r_err_code;
    w_acc         = in_valid & r_in_ready;
    w_n           = {in_data, r_len[7:0]};
    w_idx_inc     = r_idx + IDX_W'(1);
    w_word_sh     = {in_data, r_word};

    case (r_state)
      S_IDLE: begin
        if (w_acc && (in_data == SYNC)) w_state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_acc) begin
          w_len_nx   = {8'h00, in_data};
          w_state_nx = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_acc) begin
          w_len_nx = w_n;
          if ((w_n == 16'd0) || (32'(w_n) > DEPTH)) begin
            w_state_nx    = S_ERROR;
            w_error_nx    = 1'b1;
            w_err_code_nx = 2'b01;
            w_hold_nx     = 1'b1;
          end else begin
            w_state_nx = S_DATA;
            w_idx_nx   = '0;
            w_bcnt_nx  = 2'd0;
            w_sum_nx   = 8'd0;
          end
        end
      end
      S_DATA: begin
        if (w_acc) begin
          w_sum_nx  = r_sum + in_data;
          w_word_nx = w_word_sh[31:8];
          w_bcnt_nx = r_bcnt + 2'd1;
          // Fourth byte completes a little-endian word
          if (r_bcnt == 2'd3) begin
            w_we_nx    = 1'b1;
            w_addr_nx  = r_idx[ADDR_W-1:0];
            w_wdata_nx = w_word_sh;
            w_idx_nx   = w_idx_inc;
            if (16'(w_idx_inc) == r_len) w_state_nx = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (w_acc) begin
          if (in_data == r_sum) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
            w_hold_nx  = 1'b0;
          end else begin
            w_state_nx    = S_ERROR;
            w_error_nx    = 1'b1;
            w_err_code_nx = 2'b10;
            w_hold_nx     = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          w_state_nx    = S_IDLE;
          w_done_nx     = 1'b0;
          w_error_nx    = 1'b0;
          w_err_code_nx = 2'b00;
          w_hold_nx     = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_in_ready_nx = (w_state_nx != S_DONE) && (w_state_nx != S_ERROR);
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with hand-computed write logs and status.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              n_rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];

  // Reference frame: two words, checksum 0x13+0x93+0x10 = 0xB6
  logic [7:0] frame_ok [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
  logic [31:0] exp_data [2] = '{32'h0000_0013, 32'h0010_0093};

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .done(done), .error(error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each negedge with imem_we high is one write; a stretched strobe logs twice
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Offer one byte at a negedge, waiting (bounded) for in_ready.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 12; i++) begin
      send_byte(frame_ok[i]);
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error, err_code} !==
        {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b code=%b required 1 0 000 00000000 1 0 0 00",
               in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error, err_code);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    clear_log();
    send_frame(1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2) begin
      n_bad++; $display("FAIL basic_write_count: got %0d required 2", log_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (log_addr[i] !== 10'(i) || log_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL basic_write%0d: addr=%h data=%h required %h %h",
                   i, log_addr[i], log_data[i], 10'(i), exp_data[i]);
        end
      end
    end
    n_cmp++;
    if ({done, core_hold, error, in_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL basic_status: done=%b hold=%b err=%b rdy=%b required 1 0 0 0",
               done, core_hold, error, in_ready);
    end
  endtask

  task automatic test_garbage();
    do_restart();
    clear_log();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    send_frame(1'b0);
    @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2 || log_addr[0] !== 10'd0 || log_data[0] !== exp_data[0] ||
        log_addr[1] !== 10'd1 || log_data[1] !== exp_data[1]) begin
      n_bad++;
      $display("FAIL garbage_writes: count=%0d required 2 writes 0:%h 1:%h",
               log_addr.size(), exp_data[0], exp_data[1]);
    end
    n_cmp++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_bad++; $display("FAIL garbage_done: done=%b err=%b required 1 0", done, error);
    end
  endtask

  task automatic test_bad_csum();
    do_restart();
    clear_log();
    for (int i = 0; i < 11; i++) send_byte(frame_ok[i]);
    send_byte(8'hB5);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2 || log_data[0] !== exp_data[0] || log_data[1] !== exp_data[1]) begin
      n_bad++; $display("FAIL csum_writes: count=%0d required 2 with frame data", log_addr.size());
    end
    n_cmp++;
    if ({error, err_code, core_hold, in_ready, done} !== 6'b1_10_1_0_0) begin
      n_bad++;
      $display("FAIL csum_status: err=%b code=%b hold=%b rdy=%b done=%b required 1 10 1 0 0",
               error, err_code, core_hold, in_ready, done);
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] lens [4] = '{8'h00, 8'h00, 8'h01, 8'h04};
    for (int k = 0; k < 2; k++) begin
      do_restart();
      clear_log();
      send_byte(8'hA5);
      send_byte(lens[2*k]);
      send_byte(lens[2*k+1]);
      in_valid = 1'b0;
      n_cmp++;
      if ({error, err_code, in_ready, core_hold} !== 5'b1_01_0_1) begin
        n_bad++;
        $display("FAIL len%0d_status: err=%b code=%b rdy=%b hold=%b required 1 01 0 1",
                 k, error, err_code, in_ready, core_hold);
      end
      @(negedge clk);
      n_cmp++;
      if (log_addr.size() != 0) begin
        n_bad++; $display("FAIL len%0d_no_write: writes=%0d required 0", k, log_addr.size());
      end
    end
    do_restart();
    n_cmp++;
    if ({in_ready, error, err_code, core_hold} !== 5'b1_0_00_1) begin
      n_bad++;
      $display("FAIL len_restart: rdy=%b err=%b code=%b hold=%b required 1 0 00 1",
               in_ready, error, err_code, core_hold);
    end
  endtask

  task automatic test_gaps();
    clear_log();
    send_frame(1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2 || log_addr[1] !== 10'd1 || log_data[0] !== exp_data[0] ||
        log_data[1] !== exp_data[1] || done !== 1'b1 || core_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL gaps_frame: writes=%0d done=%b hold=%b required 2 1 0",
               log_addr.size(), done, core_hold);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] part [9] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_restart();
    clear_log();
    for (int i = 0; i < 9; i++) send_byte(part[i]);
    in_valid = 1'b0;
    n_cmp++;
    if (log_addr.size() != 1 || log_data[0] !== 32'h4433_2211) begin
      n_bad++; $display("FAIL mid_partial: writes=%0d required 1 of 44332211", log_addr.size());
    end
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, imem_we, core_hold, done, error, imem_addr, imem_wdata} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: rdy=%b we=%b hold=%b addr=%h wd=%h required 1 0 1 000 00000000",
               in_ready, imem_we, core_hold, imem_addr, imem_wdata);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    clear_log();
    send_frame(1'b0);
    @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2 || log_addr[0] !== 10'd0 || log_data[0] !== exp_data[0] ||
        log_data[1] !== exp_data[1] || done !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reload: writes=%0d done=%b required 2 from addr 0 and done 1",
               log_addr.size(), done);
    end
  endtask

  task automatic test_restart_collision();
    restart = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, core_hold, done} !== 3'b110) begin
      n_bad++;
      $display("FAIL collide_state: rdy=%b hold=%b done=%b required 1 1 0", in_ready, core_hold, done);
    end
    clear_log();
    send_frame(1'b0);
    @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2 || log_data[0] !== exp_data[0] || log_data[1] !== exp_data[1] ||
        done !== 1'b1 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_reload: writes=%0d done=%b err=%b required 2 1 0",
               log_addr.size(), done, error);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_garbage();
    test_bad_csum();
    test_bad_len();
    test_gaps();
    test_reset_mid();
    test_restart_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
